// File: rtl/pc_gen_if.sv
// Fetch request bus between the PC generator and instruction memory.
// The master drives the fetch address and request; the memory answers with ready.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pc;
  logic                  ce;
  logic                  req_valid;
  logic                  req_ready;

  modport master (
    output pc,
    output ce,
    output req_valid,
    input  req_ready
  );

  modport slave (
    input  pc,
    input  ce,
    input  req_valid,
    output req_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential stepping, flush and branch redirects,
// and a one-entry buffer that holds a branch target until fetch can advance.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    INST_BYTES   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STALL_WIDTH  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WIDTH-1:0] stall,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  flush_pc,
  input  logic                   branch_flag,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  pc_gen_if.master               bus,
  output logic                   redirect_pending
);

  localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(PC_INC - ADDR_WIDTH'(1));

  typedef enum logic {
    FETCH_OFF,
    FETCH_ON
  } fetch_state_t;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic                  ce;
  logic                  adv;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  pending_q;
  logic                  pending_next;
  logic [ADDR_WIDTH-1:0] target_q;
  logic [ADDR_WIDTH-1:0] target_next;
  logic                  unused_stall;

  function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  // Fetch turns on the first edge after reset releases and stays on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = FETCH_ON;
  end

  always_comb begin
    ce = (state == FETCH_ON);
  end

  // Only the fetch-stage stall bit matters; the others are deliberately ignored.
  assign unused_stall = ^stall;
  assign adv          = ce & bus.req_ready & ~stall[0];

  // Redirect priority: flush, live branch, buffered branch, then sequential step.
  always_comb begin
    pc_next      = pc_q;
    pending_next = pending_q;
    target_next  = target_q;
    if (ce) begin
      if (flush) begin
        pc_next      = align(flush_pc);
        pending_next = 1'b0;
      end else if (branch_flag && adv) begin
        pc_next      = align(branch_target);
        pending_next = 1'b0;
      end else if (branch_flag) begin
        target_next  = align(branch_target);
        pending_next = 1'b1;
      end else if (pending_q && adv) begin
        pc_next      = target_q;
        pending_next = 1'b0;
      end else if (adv) begin
        pc_next      = pc_q + PC_INC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      pending_q <= 1'b0;
      target_q  <= '0;
    end else begin
      pc_q      <= pc_next;
      pending_q <= pending_next;
      target_q  <= target_next;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.ce           = ce;
  assign bus.req_valid    = ce;
  assign redirect_pending = pending_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It is the successor of the fixed +4 PC counter, and adds the following:
- configurable address width, instruction size and reset vector
- a valid/ready fetch handshake to instruction memory
- per-stage stall input
- branch redirect, with a one-entry pending-redirect buffer for redirects that arrive while fetch is blocked
- exception/flush redirect with top priority

It sits between the control/branch logic and the instruction memory, and drives the fetch address and chip enable.

Parameters:
ADDR_WIDTH, 32, width of pc and all target addresses
INST_BYTES, 4, PC increment in bytes (power of two, >=1); low log2(INST_BYTES) bits of every target are forced to 0
RESET_VECTOR, 32'h0000_0000, pc value while disabled/after reset (ADDR_WIDTH bits, must be aligned)
STALL_WIDTH, 6, width of stall vector; bit 0 is the fetch-stage stall

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  STALL_WIDTH  per-stage stall; only stall[0] is used here
flush  in  1  exception/flush redirect request
flush_pc  in  ADDR_WIDTH  flush target (exception handler / return address)
branch_flag  in  1  branch/jump taken
branch_target  in  ADDR_WIDTH  branch destination
req_ready  in  1  instruction memory accepts the current pc this cycle
pc  out  ADDR_WIDTH  current fetch address (registered)
ce  out  1  instruction memory chip enable (registered)
req_valid  out  1  fetch request valid; combinational, equals ce
redirect_pending  out  1  pending-branch buffer occupied (registered)

Behaviour:
- Reset, sync: at any edge with rst=1, the registers update as follows:
  - ce<=0
  - pc<=RESET_VECTOR
  - redirect_pending<=0
  - pending target<=0
  - flush and branch are ignored that cycle
  - reset mid-operation discards any pending redirect.
- Enable sequencing: at an edge with rst=0, ce<=1. While ce=0 (at the sampling edge), pc holds RESET_VECTOR. The first edge after rst falls sets ce=1 with pc=RESET_VECTOR, so RESET_VECTOR is the first address presented.
- Advance condition: adv = ce & req_ready & ~stall[0]. pc changes only at an adv edge, except on flush.
- Next-pc priority at an edge with rst=0 and ce=1:
  1. flush=1: pc<=align(flush_pc), and redirect_pending<=0. Applied regardless of stall/req_ready; also overrides a simultaneous branch_flag.
  2. branch_flag=1 & adv: pc<=align(branch_target), and redirect_pending<=0. A newer branch wins over the buffered one.
  3. branch_flag=1 & ~adv: buffer the target, redirect_pending<=1, pc held. If the buffer is already full it is overwritten, so the newest wins.
  4. redirect_pending=1 & adv: pc<=buffered target, and redirect_pending<=0.
  5. adv: pc<=pc+INST_BYTES, modulo 2^ADDR_WIDTH (wraps to 0, no flag).
  6. otherwise: pc, redirect_pending and the buffer hold.
- When ce=0: flush and branch_flag are ignored and nothing is buffered.
- align(x) = x with the low log2(INST_BYTES) bits cleared. For INST_BYTES=1, no bits are cleared.
- Latency:
  - A redirect taken at an edge is visible on pc in the following cycle (1 cycle).
  - A buffered redirect appears one cycle after the first subsequent adv edge.
- req_valid=ce. pc is stable whenever req_valid=1 & ~adv; the memory may sample it across wait cycles.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0; req_ready=1, stall=0. Required: ce=0 and pc=0 during reset; first cycle after release ce=1, pc=0; then pc steps 4, 8, 12 on successive cycles.
- Backpressure/stall: run to pc=0x10, then hold req_ready=0 for 2 cycles, then stall[0]=1 for 2 cycles. Required: pc stays 0x10 for 4 cycles, then 0x14. Check also that stall[5:1] alone does not hold pc.
- Branch while blocked: at pc=0x20 with req_ready=0, pulse branch_flag with target 0x103. Required: redirect_pending=1, pc=0x20. When req_ready returns: pc=0x100, redirect_pending=0. Repeat with a second branch to 0x200 before ready returns; required result pc=0x200.
- Flush priority: in the same cycle, flush=1 (flush_pc=0x80), branch_flag=1 (target 0x40), stall[0]=1, and a buffered redirect pending. Required: next pc=0x80 and redirect_pending=0.
- Wrap/params: ADDR_WIDTH=16, INST_BYTES=2, RESET_VECTOR=16'hFFFC. Required: pc sequence FFFC, FFFE, 0000, 0002.
- Reset mid-operation: assert rst for 1 cycle while redirect_pending=1 and pc=0x300. Required: next cycle ce=0, pc=RESET_VECTOR, redirect_pending=0. The cycle after that: ce=1 and pc unchanged; fetch resumes from RESET_VECTOR.
